// File: rtl/pkt_fifo_ctrl.sv
// Pointer/flag controller for a 128x8 packet FIFO with commit/abort rollback.
// Optional sticky error flags are enabled with `define PKT_FIFO_CTRL_ERR_EN.
module pkt_fifo_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int AFULL_LVL = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pkt_start,
  input  logic              wr_req,
  input  logic              pkt_commit,
  input  logic              pkt_abort,
  input  logic              rd_req,
  output logic              mem_w_en,
  output logic              mem_full,
  output logic [ADDR_W-1:0] w_count,
  output logic [ADDR_W-1:0] r_count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   rd_avail,
  output logic              pkt_open,
  output logic              pkt_dropped,
`ifdef PKT_FIFO_CTRL_ERR_EN
  output logic              err_ovf,
  output logic              err_udf,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a byte is written when mem_w_en is high at the rising edge;
  // a byte is popped when rd_req is high and empty is low at the rising edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] cm_ptr_q, cm_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wr_inc;
  logic [ADDR_W:0] fill;
  logic            open_eff;
  logic            drop_d;

  assign fill        = wr_ptr_q - rd_ptr_q;
  assign full        = (fill == DEPTH);
  assign empty       = (cm_ptr_q == rd_ptr_q);
  assign rd_avail    = cm_ptr_q - rd_ptr_q;
  assign almost_full = (fill >= AFULL);
  assign mem_full    = full;
  assign w_count     = wr_ptr_q[ADDR_W-1:0];
  assign r_count     = rd_ptr_q[ADDR_W-1:0];
  assign pkt_open    = (state_q == OPEN);
  assign dbg_state   = state_q;

  // pkt_start in IDLE behaves as if the packet were already open this cycle.
  assign open_eff = (state_q == OPEN) || ((state_q == IDLE) && pkt_start);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_inc   = wr_ptr_q;
    drop_d   = 1'b0;
    mem_w_en = 1'b0;
    if (flush) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      cm_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (rd_req && !empty) rd_ptr_d = rd_ptr_q + ONE;
      if (open_eff) begin
        if (pkt_abort) begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
          state_d  = IDLE;
        end else if (wr_req && full) begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
          state_d  = DROP;
        end else begin
          mem_w_en = wr_req;
          wr_inc   = wr_req ? (wr_ptr_q + ONE) : wr_ptr_q;
          wr_ptr_d = wr_inc;
          if (pkt_commit) begin
            cm_ptr_d = wr_inc;
            state_d  = IDLE;
          end else begin
            state_d  = OPEN;
          end
        end
      end else if ((state_q == DROP) && (pkt_commit || pkt_abort)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_dropped <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_dropped <= drop_d;
    end
  end

`ifdef PKT_FIFO_CTRL_ERR_EN
  logic ovf_evt, udf_evt;
  assign ovf_evt = open_eff && wr_req && full;
  assign udf_evt = rd_req && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (flush) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (ovf_evt) err_ovf <= 1'b1;
      if (udf_evt) err_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Directed bench for pkt_fifo_ctrl: models the 128x8 memory, keeps an expected
// byte queue per committed packet and checks read data and rd_avail from a monitor.
module tb_pkt_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       pkt_start = 1'b0;
  logic       wr_req = 1'b0;
  logic       pkt_commit = 1'b0;
  logic       pkt_abort = 1'b0;
  logic       rd_req = 1'b0;
  logic       mem_w_en, mem_full, empty, full, almost_full, pkt_open, pkt_dropped;
  logic [6:0] w_count, r_count;
  logic [7:0] rd_avail;
  logic [1:0] dbg_state;
`ifdef PKT_FIFO_CTRL_ERR_EN
  logic       err_ovf, err_udf;
`endif

  logic [7:0] wdata = 8'h00;
  logic [7:0] data_ctr = 8'h01;
  logic [7:0] mem [128];
  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         drop_cnt = 0;

  pkt_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .pkt_start(pkt_start), .wr_req(wr_req),
    .pkt_commit(pkt_commit), .pkt_abort(pkt_abort), .rd_req(rd_req),
    .mem_w_en(mem_w_en), .mem_full(mem_full), .w_count(w_count), .r_count(r_count),
    .empty(empty), .full(full), .almost_full(almost_full), .rd_avail(rd_avail),
    .pkt_open(pkt_open), .pkt_dropped(pkt_dropped),
`ifdef PKT_FIFO_CTRL_ERR_EN
    .err_ovf(err_ovf), .err_udf(err_udf),
`endif
    .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) mem[w_count] <= wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // monitor: pops expected bytes whenever the DUT presents a readable byte
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rd_avail_model", 32'(rd_avail), 32'(exp_q.size()));
        if (rd_req && !empty) begin
          if (exp_q.size() == 0) chk("rd_unexpected", 32'(r_count), 32'hFFFF);
          else chk("rd_data", 32'(mem[r_count]), 32'(exp_q.pop_front()));
        end
        if (pkt_dropped) drop_cnt++;
      end
    end
  endtask

  // driver: one cycle of stimulus; acc means the write is expected to be accepted
  task automatic drive(input logic s, input logic w, input logic c, input logic a,
                       input logic r, input logic acc);
    pkt_start = s; wr_req = w; pkt_commit = c; pkt_abort = a; rd_req = r;
    wdata = data_ctr;
    @(posedge clk);
    if (w && acc) begin
      pend_q.push_back(wdata);
      data_ctr++;
    end
    if (a) pend_q.delete();
    if (c) begin
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
    end
    #1;
    pkt_start = 0; wr_req = 0; pkt_commit = 0; pkt_abort = 0; rd_req = 0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    pend_q.delete();
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!empty && n < 300) begin
      drive(0, 0, 0, 0, 1, 0);
      n++;
    end
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    int d0;
    fork monitor(); join_none

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_rd_avail", 32'(rd_avail), 32'd0);
    chk("rst_w_count", 32'(w_count), 32'd0);
    chk("rst_r_count", 32'(r_count), 32'd0);
    chk("rst_pkt_open", 32'(pkt_open), 32'd0);
    chk("rst_dropped", 32'(pkt_dropped), 32'd0);
    wr_req = 1'b1;
    #1 chk("idle_wr_ignored", 32'(mem_w_en), 32'd0);
    drive(0, 1, 0, 0, 0, 0);
    chk("idle_w_count", 32'(w_count), 32'd0);

    // six-byte packet, commit on the sixth write, then read back
    drive(1, 1, 0, 0, 0, 1);
    chk("open_after_start", 32'(pkt_open), 32'd1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 1);
    chk("pre_commit_avail", 32'(rd_avail), 32'd0);
    drive(0, 1, 1, 0, 0, 1);
    chk("commit_avail", 32'(rd_avail), 32'd6);
    chk("commit_empty", 32'(empty), 32'd0);
    chk("commit_idle", 32'(pkt_open), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("rd_r_count", 32'(r_count), 32'(i));
      drive(0, 0, 0, 0, 1, 0);
    end
    chk("rd_done_empty", 32'(empty), 32'd1);
    chk("rd_done_r_count", 32'(r_count), 32'd6);

    // abort rollback
    do_flush();
    chk("flush_w_count", 32'(w_count), 32'd0);
    d0 = drop_cnt;
    drive(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0, 1);
    chk("abort_pre_w_count", 32'(w_count), 32'd10);
    drive(0, 1, 0, 1, 0, 0);
    chk("abort_dropped", 32'(pkt_dropped), 32'd1);
    chk("abort_w_count", 32'(w_count), 32'd0);
    chk("abort_rd_avail", 32'(rd_avail), 32'd0);
    drive(1, 1, 0, 0, 0, 1);
    chk("abort_pulse_end", 32'(pkt_dropped), 32'd0);
    chk("abort_pulse_once", 32'(drop_cnt - d0), 32'd1);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    chk("pkt3_avail", 32'(rd_avail), 32'd3);
    chk("pkt3_r_count", 32'(r_count), 32'd0);
    drain();

    // fill 128 bytes, almost_full boundary, overflow into DROP
    do_flush();
    for (int i = 1; i <= 128; i++) begin
      drive(i == 1, 1, i == 128, 0, 0, 1);
      if (i == 119) chk("afull_119", 32'(almost_full), 32'd0);
      if (i == 120) chk("afull_120", 32'(almost_full), 32'd1);
      if (i == 127) chk("full_127", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_mem_full", 32'(mem_full), 32'd1);
    chk("fill_avail", 32'(rd_avail), 32'd128);
    pkt_start = 1'b1; wr_req = 1'b1; wdata = 8'hEE;
    #1 chk("ovf_mem_w_en", 32'(mem_w_en), 32'd0);
    @(posedge clk);
    #1 pkt_start = 1'b0; wr_req = 1'b0;
    chk("ovf_state_drop", 32'(dbg_state), 32'd2);
    chk("ovf_dropped", 32'(pkt_dropped), 32'd1);
`ifdef PKT_FIFO_CTRL_ERR_EN
    chk("ovf_err_ovf", 32'(err_ovf), 32'd1);
`endif
    wr_req = 1'b1;
    #1 chk("drop_mem_w_en", 32'(mem_w_en), 32'd0);
    @(posedge clk);
    #1 wr_req = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    chk("drop_commit_idle", 32'(dbg_state), 32'd0);
    chk("drop_commit_avail", 32'(rd_avail), 32'd128);
    chk("drop_w_count", 32'(w_count), 32'd0);
    drain();
    chk("fill_drained_r_count", 32'(r_count), 32'd0);

    // three 100-byte packets with concurrent reads across the wrap
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 100; i++) drive(i == 0, 1, i == 99, 0, 1, 1);
      if (p == 0) chk("wrap_w_count_100", 32'(w_count), 32'd100);
      if (p == 1) chk("wrap_w_count_200", 32'(w_count), 32'd72);
      if (p == 2) chk("wrap_w_count_300", 32'(w_count), 32'd44);
    end
    drain();
    chk("wrap_r_count", 32'(r_count), 32'd44);

    // flush mid-packet with 40 committed bytes
    do_flush();
`ifdef PKT_FIFO_CTRL_ERR_EN
    chk("flush_err_udf_clr", 32'(err_udf), 32'd0);
    drive(0, 0, 0, 0, 1, 0);
    chk("udf_set", 32'(err_udf), 32'd1);
`endif
    for (int i = 0; i < 40; i++) drive(i == 0, 1, i == 39, 0, 0, 1);
    chk("flush_pre_avail", 32'(rd_avail), 32'd40);
    for (int i = 0; i < 5; i++) drive(i == 0, 1, 0, 0, 0, 1);
    chk("flush_pre_open", 32'(pkt_open), 32'd1);
    do_flush();
    chk("flush_rd_avail", 32'(rd_avail), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_w_count0", 32'(w_count), 32'd0);
    chk("flush_r_count0", 32'(r_count), 32'd0);
    chk("flush_state", 32'(dbg_state), 32'd0);
    chk("flush_no_drop", 32'(pkt_dropped), 32'd0);
`ifdef PKT_FIFO_CTRL_ERR_EN
    chk("flush_err_udf", 32'(err_udf), 32'd0);
    chk("flush_err_ovf", 32'(err_ovf), 32'd0);
`endif
    drive(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_fifo_ctrl.md
Name: pkt_fifo_ctrl

Overview:
- Single-clock pointer and flag controller for the 128 x 8 FIFO memory in the packet processor.
- Drives the memory's write enable, full, write address and read address.
- Provides packet-granular writes: bytes become readable only after the packet is committed, and an aborted or overflowed packet is rolled back.
- Sits between the packet assembler (write side) and the downstream consumer (read side).

Parameters:
- ADDR_W, 7, memory address width; depth = 2**ADDR_W = 128.
- AFULL_LVL, 120, almost_full asserts when stored bytes (committed + open) >= AFULL_LVL.

Ports:
- clk  in  1  system clock; also drives the memory write clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of all pointers and state.
- pkt_start  in  1  opens a packet.
- wr_req  in  1  write one byte at w_count this cycle.
- pkt_commit  in  1  closes the packet; its bytes become readable.
- pkt_abort  in  1  discards the open packet.
- rd_req  in  1  pop one committed byte.
- mem_w_en  out  1  to memory w_en.
- mem_full  out  1  to memory full.
- w_count  out  ADDR_W  memory write address.
- r_count  out  ADDR_W  memory read address; read data is combinational from this.
- empty  out  1  no committed bytes available.
- full  out  1  no free entries.
- almost_full  out  1  fill level >= AFULL_LVL.
- rd_avail  out  ADDR_W+1  committed bytes available, 0..128.
- pkt_open  out  1  state is OPEN.
- pkt_dropped  out  1  one-cycle pulse when a packet is rolled back (abort or overflow).

Behaviour:
- Pointers: wr_ptr, cm_ptr and rd_ptr are each ADDR_W+1 bits, with the MSB as the wrap bit. All pointer arithmetic is modulo 256.
- Derived outputs:
  - w_count = wr_ptr[6:0]; r_count = rd_ptr[6:0].
  - full = (wr_ptr - rd_ptr) == 128.
  - empty = (cm_ptr == rd_ptr).
  - rd_avail = cm_ptr - rd_ptr.
  - almost_full = (wr_ptr - rd_ptr) >= AFULL_LVL.
  - mem_full = full.
- Reset: all pointers 0, state IDLE. Outputs at reset: empty=1, full=0, almost_full=0, rd_avail=0, pkt_open=0, pkt_dropped=0, mem_w_en=0, w_count=0, r_count=0.
- Priority each cycle: rst > flush > pkt_abort > overflow > pkt_commit > wr_req.
- Flush: zeroes all pointers and returns to IDLE next cycle. pkt_dropped does not pulse.
- State machine:
  - IDLE: pkt_start -> OPEN. wr_req is ignored unless pkt_start is asserted in the same cycle; then that byte is written.
  - OPEN, write accepted: mem_w_en = wr_req & !full (combinational). On an accepted write, wr_ptr increments.
  - OPEN, overflow: wr_req while full -> wr_ptr <= cm_ptr, pkt_dropped pulses, state -> DROP.
  - OPEN, pkt_commit: cm_ptr <= wr_ptr + accepted write this cycle (0 or 1), state -> IDLE. A commit of a zero-byte packet is legal and has no effect.
  - OPEN, pkt_abort: wr_ptr <= cm_ptr, pkt_dropped pulses, state -> IDLE. A same-cycle wr_req is discarded.
  - OPEN, pkt_start: ignored.
  - DROP: all writes are blocked and mem_w_en = 0. pkt_commit or pkt_abort -> IDLE with no pointer change.
- Read side:
  - rd_req & !empty: rd_ptr increments next edge.
  - The byte at r_count is valid combinationally while !empty.
  - rd_req while empty is ignored.
- Concurrency:
  - Reads and writes in the same cycle are independent.
  - full is evaluated on pre-edge pointers; a same-cycle read does not unblock a write.
  - A read can never pass cm_ptr, so uncommitted bytes are never exposed.
- rst mid-packet discards all content immediately (asynchronous).

Optional Feature:
- Macro: PKT_FIFO_CTRL_ERR_EN.
- When defined, adds output ports:
  - err_ovf (1): sticky; set on wr_req while full in OPEN.
  - err_udf (1): sticky; set on rd_req while empty.
  - Both are cleared by rst or flush.
- When undefined, the ports are absent and no error logic is synthesized.

Test Plan:
- Reset then idle -> empty=1, full=0, rd_avail=0, w_count=r_count=0, mem_w_en never asserted.
- pkt_start + 5 wr_req, then pkt_commit on the 6th write -> after commit rd_avail=6, empty=0. Six rd_req -> r_count steps 0..5, then empty=1 and r_count=6.
- 10 bytes written then pkt_abort -> pkt_dropped pulses once, w_count returns to 0, rd_avail stays 0. A following 3-byte packet lands at addresses 0..2.
- Fill 128 bytes in one packet and commit -> full=1, almost_full=1 from byte 120. A new packet's wr_req gives mem_w_en=0 and a DROP transition. pkt_commit -> IDLE with rd_avail still 128.
- Steady stream across wrap: 3 x 100-byte packets with concurrent reads -> w_count wraps 127->0, rd_avail is always exact, data order is preserved.
- flush asserted mid-packet with rd_avail=40 -> next cycle all pointers 0, empty=1, state IDLE. With PKT_FIFO_CTRL_ERR_EN defined, an earlier rd_req on empty sets err_udf, and flush clears it.
